modport_dpram: RTL and testbench

- Simple dual-port synchronous RAM: one write port and one independent read port, both on a single clock.
- Default geometry is 32 words x 8 bits.
- Sits behind the team's driver/monitor interface:
  - The driver applies wr_en, rd_en, wr_addr, rd_addr and w_data on the clock edge.
  - The monitor samples all of those plus r_data.
- Write and read may occur in the same cycle, to any address pair.

---
 rtl/modport_dpram.sv | 57 +++++
 tb/tb_modport_dpram.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/modport_dpram.sv
// Simple dual-port register-file RAM: one write port, one read port, single clock.
// Registered read data with write-first behaviour when both ports hit the same word.
module modport_dpram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    // There is no handshake: the driver may present one write and one read on
    // every rising edge and both are always accepted; r_data is valid the cycle
    // after the edge that sampled rd_en and holds until the next read or reset.

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [DATA_WIDTH-1:0] r_data_d;
    logic                  collide;

    assign collide = wr_en && rd_en && (wr_addr == rd_addr);

    // Write-first: a colliding read returns the word being written this edge.
    always_comb begin
        r_data_d = r_data_q;
        if (rd_en) begin
            r_data_d = collide ? w_data : mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_q <= '0;
        end else begin
            r_data_q <= r_data_d;
        end
    end

    assign r_data = r_data_q;

endmodule

// File: tb/tb_modport_dpram.sv
// Randomised scoreboard bench for modport_dpram: the driver pushes expected
// read data from an array model; a monitor pops and compares after each edge.
module tb_modport_dpram;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] w_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] r_data;

    modport_dpram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .w_data (w_data),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .r_data (r_data)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model and scoreboard
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] hold_val;
    int            n_tests;
    int            n_fail;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one operation per cycle, inputs changed on the falling edge
    task automatic op(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit re, input logic [AW-1:0] ra);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        w_data  = wd;
        rd_en   = re;
        rd_addr = ra;
        if (rst) begin
            if (re) exp_q.push_back((we && wa == ra) ? wd : ref_mem[ra]);
            if (we) ref_mem[wa] = wd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        op(1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        op(1'b0, '0, '0, 1'b1, a);
    endtask

    // Reset asserted between edges; r_data must clear without waiting for clk.
    task automatic pulse_reset(input string name, input int cycles, input bit busy);
        @(negedge clk);
        wr_en   = busy;
        rd_en   = busy;
        wr_addr = AW'(10);
        rd_addr = AW'(10);
        w_data  = 8'hEE;
        #2 rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        hold_val = '0;
        #1 check({name, "_async_clear"}, r_data, 8'h00);
        for (int i = 0; i < cycles; i++) @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // monitor
    logic rd_issued;
    always @(posedge clk) begin
        rd_issued = rst && rd_en;
        #1;
        if (rd_issued) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL read_unexpected: got 0x%02h expected no read at %0t", r_data, $time);
            end else begin
                hold_val = exp_q.pop_front();
                check("read_data", r_data, hold_val);
            end
        end else begin
            check("read_hold", r_data, hold_val);
        end
    end

    logic [AW-1:0] ra, wa;
    bit            re, we;

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        hold_val = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        w_data  = '0;
        #1 check("reset_r_data", r_data, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // reset then read every word
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));

        // basic write / read
        wr(AW'(3), 8'hA5);
        rd(AW'(3));
        rd(AW'(4));

        // collision: write-first
        wr(AW'(7), 8'h11);
        op(1'b1, AW'(7), 8'h3C, 1'b1, AW'(7));
        rd(AW'(7));

        // hold while the read word is overwritten
        rd(AW'(3));
        op(1'b1, AW'(3), 8'hFF, 1'b0, '0);
        idle(3);
        rd(AW'(3));

        // boundary addresses
        wr(AW'(31), 8'h81);
        wr(AW'(0), 8'h18);
        rd(AW'(31));
        rd(AW'(0));

        // simultaneous write/read to different words returns old data
        op(1'b1, AW'(0), 8'h99, 1'b1, AW'(31));
        rd(AW'(0));

        // randomised traffic with frequent collisions
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 3) != 0);
            re = ($urandom_range(0, 3) != 0);
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            op(we, wa, DW'($urandom_range(0, 255)), re, ra);
        end

        // mid-operation reset with enables held high during reset
        wr(AW'(10), 8'h55);
        rd(AW'(10));
        idle(1);
        pulse_reset("mid_reset", 2, 1'b1);
        rd(AW'(10));
        for (int i = 0; i < 8; i++) rd(AW'($urandom_range(0, DEPTH - 1)));
        idle(2);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
